// File: rtl/slim_combat_ctrl.sv
// Per-frame combat sequencer for the slim group: attack edge detect, per-player cooldown,
// target arbitration, per-slim ALIVE/DYING/GONE and wave clear/respawn. Kills register on the attack edge.
module slim_combat_ctrl #(
    parameter int NUM_SLIM        = 3,
    parameter int DEATH_FRAMES    = 64,
    parameter int COOLDOWN_FRAMES = 16,
    parameter int RESPAWN_FRAMES  = 120
) (
    input  logic                  frame_clk,
    input  logic                  RESET,
    input  logic [1:0]            fight,
    input  logic [NUM_SLIM-1:0]   reach0,
    input  logic [NUM_SLIM-1:0]   reach1,
    output logic [NUM_SLIM-1:0]   dead,
    output logic [NUM_SLIM-1:0]   not_display,
    output logic [NUM_SLIM*6-1:0] death_cnt,
    output logic [NUM_SLIM-1:0]   killer,
    output logic [7:0]            score0,
    output logic [7:0]            score1,
    output logic [3:0]            wave,
    output logic                  wave_clear,
    output logic [1:0]            cooldown_busy
);

    localparam logic [1:0] S_ALIVE = 2'd0;
    localparam logic [1:0] S_DYING = 2'd1;
    localparam logic [1:0] S_GONE  = 2'd2;

    localparam logic [0:0] PLAY  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    localparam logic [5:0] CD_LOAD    = 6'(COOLDOWN_FRAMES);
    localparam logic [5:0] DEATH_LAST = 6'(DEATH_FRAMES - 1);
    localparam logic [7:0] RC_LOAD    = 8'(RESPAWN_FRAMES - 1);

    logic [1:0]          slim_st [NUM_SLIM];
    logic [5:0]          dcnt    [NUM_SLIM];
    logic [1:0]          fight_q;
    logic [5:0]          cd0;
    logic [5:0]          cd1;
    logic                prio;
    logic [0:0]          wave_st;
    logic [7:0]          rc;

    logic [NUM_SLIM-1:0] alive;
    logic [NUM_SLIM-1:0] cand0;
    logic [NUM_SLIM-1:0] cand1;
    logic [NUM_SLIM-1:0] pick0;
    logic [NUM_SLIM-1:0] pick1;
    logic [NUM_SLIM-1:0] kill0;
    logic [NUM_SLIM-1:0] kill1;
    logic [1:0]          atk;
    logic                prio_flip;
    logic                all_gone;
    logic                respawn;

    function automatic logic [NUM_SLIM-1:0] lowest_set(input logic [NUM_SLIM-1:0] v);
        logic [NUM_SLIM-1:0] r;
        r = '0;
        for (int i = NUM_SLIM - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        alive       = '0;
        dead        = '0;
        not_display = '0;
        death_cnt   = '0;
        for (int i = 0; i < NUM_SLIM; i++) begin
            alive[i]             = (slim_st[i] == S_ALIVE);
            dead[i]              = (slim_st[i] != S_ALIVE);
            not_display[i]       = (slim_st[i] == S_GONE);
            death_cnt[i*6 +: 6]  = dcnt[i];
        end
        all_gone      = &not_display;
        respawn       = (wave_st == CLEAR) && (rc == 8'd0);
        wave_clear    = (wave_st == CLEAR);
        cooldown_busy = {cd1 != 6'd0, cd0 != 6'd0};

        atk[0] = fight[0] & ~fight_q[0] & (cd0 == 6'd0);
        atk[1] = fight[1] & ~fight_q[1] & (cd1 == 6'd0);

        cand0 = reach0 & alive & {NUM_SLIM{wave_st == PLAY}};
        cand1 = reach1 & alive & {NUM_SLIM{wave_st == PLAY}};
        pick0 = lowest_set(cand0);
        pick1 = lowest_set(cand1);

        // On a simultaneous attack the prio player picks first; the other takes what remains.
        kill0 = '0;
        kill1 = '0;
        if (atk[0] && atk[1]) begin
            if (!prio) begin
                kill0 = pick0;
                kill1 = lowest_set(cand1 & ~pick0);
            end else begin
                kill1 = pick1;
                kill0 = lowest_set(cand0 & ~pick1);
            end
        end else if (atk[0]) begin
            kill0 = pick0;
        end else if (atk[1]) begin
            kill1 = pick1;
        end
        prio_flip = atk[0] && atk[1] && (pick0 != '0) && (pick0 == pick1);
    end

    always_ff @(posedge frame_clk or posedge RESET) begin
        if (RESET) begin
            fight_q <= 2'b11;
            cd0     <= '0;
            cd1     <= '0;
            prio    <= 1'b0;
            wave_st <= PLAY;
            rc      <= '0;
            score0  <= '0;
            score1  <= '0;
            wave    <= '0;
            killer  <= '0;
            for (int i = 0; i < NUM_SLIM; i++) begin
                slim_st[i] <= S_ALIVE;
                dcnt[i]    <= '0;
            end
        end else begin
            fight_q <= fight;

            if (atk[0])              cd0 <= CD_LOAD;
            else if (cd0 != 6'd0)    cd0 <= cd0 - 6'd1;
            if (atk[1])              cd1 <= CD_LOAD;
            else if (cd1 != 6'd0)    cd1 <= cd1 - 6'd1;

            if (prio_flip) prio <= ~prio;

            if (kill0 != '0 && score0 != 8'd255) score0 <= score0 + 8'd1;
            if (kill1 != '0 && score1 != 8'd255) score1 <= score1 + 8'd1;

            case (wave_st)
                PLAY: begin
                    if (all_gone) begin
                        wave_st <= CLEAR;
                        rc      <= RC_LOAD;
                    end
                end
                default: begin
                    if (rc == 8'd0) begin
                        wave_st <= PLAY;
                        if (wave != 4'd15) wave <= wave + 4'd1;
                    end else begin
                        rc <= rc - 8'd1;
                    end
                end
            endcase

            for (int i = 0; i < NUM_SLIM; i++) begin
                if (respawn) begin
                    slim_st[i] <= S_ALIVE;
                    dcnt[i]    <= '0;
                    killer[i]  <= 1'b0;
                end else begin
                    case (slim_st[i])
                        S_ALIVE: begin
                            if (kill0[i] || kill1[i]) begin
                                slim_st[i] <= S_DYING;
                                dcnt[i]    <= '0;
                                killer[i]  <= kill1[i];
                            end
                        end
                        S_DYING: begin
                            if (dcnt[i] == DEATH_LAST) slim_st[i] <= S_GONE;
                            else                       dcnt[i]    <= dcnt[i] + 6'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_slim_combat_ctrl.sv
// Directed bench for slim_combat_ctrl with default parameters (3 slims, 64/16/120 frames).
module tb_slim_combat_ctrl;

    logic        frame_clk = 1'b0;
    logic        RESET;
    logic [1:0]  fight;
    logic [2:0]  reach0;
    logic [2:0]  reach1;
    logic [2:0]  dead;
    logic [2:0]  not_display;
    logic [17:0] death_cnt;
    logic [2:0]  killer;
    logic [7:0]  score0;
    logic [7:0]  score1;
    logic [3:0]  wave;
    logic        wave_clear;
    logic [1:0]  cooldown_busy;

    int errors = 0;
    int checks = 0;
    int exp_s0 = 0;
    int exp_s1 = 0;

    slim_combat_ctrl dut (
        .frame_clk    (frame_clk),
        .RESET        (RESET),
        .fight        (fight),
        .reach0       (reach0),
        .reach1       (reach1),
        .dead         (dead),
        .not_display  (not_display),
        .death_cnt    (death_cnt),
        .killer       (killer),
        .score0       (score0),
        .score1       (score1),
        .wave         (wave),
        .wave_clear   (wave_clear),
        .cooldown_busy(cooldown_busy)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Player 0 waits out its cooldown and for a live slim, then strikes anything in reach.
    task automatic p0_strike();
        int n;
        fight[0] = 1'b0;
        reach0   = 3'b111;
        repeat (17) tick();
        n = 0;
        while (dead == 3'b111 && n < 300) begin
            tick();
            n++;
        end
        check("alive_wait", dead != 3'b111, 1);
        fight[0] = 1'b1;
        tick();
        exp_s0 = (exp_s0 == 255) ? 255 : exp_s0 + 1;
        check("score0_strike", score0, exp_s0);
    endtask

    task automatic clear_wave();
        int n;
        n = 0;
        while (dead != 3'b111 && n < 4) begin
            p0_strike();
            n++;
        end
        n = 0;
        while (!wave_clear && n < 300) begin
            tick();
            n++;
        end
        check("clear_rise", wave_clear, 1);
        n = 0;
        while (wave_clear && n < 200) begin
            tick();
            n++;
        end
        check("clear_fall", {wave_clear, dead}, 4'b0000);
    endtask

    initial begin
        int n;
        RESET  = 1'b1;
        fight  = 2'b01;
        reach0 = 3'b110;
        reach1 = 3'b000;
        tick();
        tick();
        check("rst_dead", dead, 0);
        check("rst_notdisp", not_display, 0);
        check("rst_dcnt", death_cnt, 0);
        check("rst_killer", killer, 0);
        check("rst_scores", {score0, score1}, 0);
        check("rst_wave", {wave, wave_clear}, 0);
        check("rst_busy", cooldown_busy, 0);

        // fight held high across reset release is not an attack
        RESET = 1'b0;
        repeat (3) tick();
        check("held_no_kill", dead, 0);
        check("held_no_cd", cooldown_busy, 0);

        fight = 2'b00; tick();
        fight = 2'b01; tick();
        exp_s0 = 1;
        check("k1_dead", dead, 3'b010);
        check("k1_killer", killer, 3'b000);
        check("k1_score0", score0, exp_s0);
        check("k1_busy", cooldown_busy, 2'b01);
        check("k1_dcnt", death_cnt[11:6], 0);
        repeat (15) tick();
        check("cd_last_busy", cooldown_busy, 2'b01);
        check("dcnt_15", death_cnt[11:6], 15);
        tick();
        check("cd_expired", cooldown_busy, 2'b00);
        check("dcnt_16", death_cnt[11:6], 16);

        // miss still loads cooldown; early re-press ignored; press at +17 accepted
        fight = 2'b00; reach0 = 3'b000; tick();
        fight = 2'b01; tick();
        check("miss_score", score0, exp_s0);
        check("miss_busy", cooldown_busy, 2'b01);
        check("miss_dead", dead, 3'b010);
        fight = 2'b00; repeat (4) tick();
        fight = 2'b01; reach0 = 3'b001; tick();
        check("cd_ignore_dead", dead, 3'b010);
        check("cd_ignore_score", score0, exp_s0);
        fight = 2'b00; repeat (11) tick();
        check("cd_clear_16", cooldown_busy, 2'b00);
        fight = 2'b01; tick();
        exp_s0 = 2;
        check("cd_accept_dead", dead, 3'b011);
        check("cd_accept_score", score0, exp_s0);

        fight = 2'b11; reach1 = 3'b100; tick();
        exp_s1 = 1;
        check("p1_killer", killer, 3'b100);
        check("p1_dead", dead, 3'b111);
        check("p1_score1", score1, exp_s1);

        repeat (63) tick();
        check("s2_dcnt63", death_cnt[17:12], 63);
        check("s2_still_dying", not_display, 3'b011);
        tick();
        check("all_gone", not_display, 3'b111);
        check("gone_dcnt", death_cnt, {6'd63, 6'd63, 6'd63});
        check("gone_no_clear", wave_clear, 0);
        tick();
        check("clear_rise1", wave_clear, 1);
        repeat (119) tick();
        check("clear_hold", {wave_clear, wave}, 5'b1_0000);
        tick();
        check("respawn_clear", wave_clear, 0);
        check("respawn_dead", dead, 0);
        check("respawn_wave", wave, 1);
        check("respawn_dcnt", death_cnt, 0);
        check("respawn_killer", killer, 0);

        // tie on slim0, prio=0: player 0 wins, player 1 gets nothing
        fight = 2'b00; reach0 = 3'b001; reach1 = 3'b001; tick();
        fight = 2'b11; tick();
        exp_s0 = 3;
        check("tie0_dead", dead, 3'b001);
        check("tie0_killer", killer, 3'b000);
        check("tie0_scores", {score0, score1}, {8'd3, 8'd1});
        check("tie0_busy", cooldown_busy, 2'b11);
        reach1 = 3'b000;
        clear_wave();
        check("wave2", wave, 2);

        // same tie after the flip: player 1 wins
        fight = 2'b00; reach0 = 3'b001; reach1 = 3'b001; tick();
        fight = 2'b11; tick();
        exp_s1 = 2;
        check("tie1_dead", dead, 3'b001);
        check("tie1_killer", killer, 3'b001);
        check("tie1_scores", {score0, score1}, {8'(exp_s0), 8'(exp_s1)});
        reach1 = 3'b000;
        clear_wave();
        check("wave3", wave, 3);

        // both reach 011 with prio back at 0: each gets a slim
        fight = 2'b00; reach0 = 3'b011; reach1 = 3'b011; tick();
        fight = 2'b11; tick();
        exp_s0++;
        exp_s1++;
        check("split_dead", dead, 3'b011);
        check("split_killer", killer, 3'b010);
        check("split_scores", {score0, score1}, {8'(exp_s0), 8'(exp_s1)});
        reach1 = 3'b000;
        clear_wave();
        check("wave4", wave, 4);

        n = 0;
        while (exp_s0 < 255 && n < 400) begin
            p0_strike();
            n++;
        end
        p0_strike();
        check("score0_sat", score0, 8'd255);
        check("wave_sat", wave, 4'd15);
        check("score1_kept", score1, exp_s1);

        // reset in the middle of the respawn countdown
        n = 0;
        while (dead != 3'b111 && n < 4) begin
            p0_strike();
            n++;
        end
        n = 0;
        while (!wave_clear && n < 300) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check("pre_rst_clear", wave_clear, 1);
        RESET = 1'b1;
        #1;
        check("mid_rst_wave", wave, 0);
        check("mid_rst_dead", dead, 0);
        check("mid_rst_clear", wave_clear, 0);
        check("mid_rst_score", {score0, score1}, 0);
        check("mid_rst_busy", cooldown_busy, 0);
        check("mid_rst_dcnt", death_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
